time_keeper: RTL
================

# time_keeper

Time-of-day counter that receives the `hit` square wave from the seconds-rate generator and turns each rising edge into exactly one one-second advance of a 24-hour BCD hours:minutes:seconds clock. It sits between the seconds generator and the display/multiplexing logic of the clock design. It also provides single-cycle tick outputs and user set/clear controls.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth for `hit`. Legal values are 2 or 3.

Ports:
- `ck` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset. Low forces every register to its reset value immediately.
- `hit` in 1: toggling level from the seconds generator. One full period is one second. Each 0→1 transition counts as one second.
- `run` in 1: high lets seconds advance; low freezes time.
- `clear` in 1: synchronous clear to 00:00:00.
- `set_min` in 1: one-cycle pulse, already debounced; advances minutes by one.
- `set_hour` in 1: one-cycle pulse, already debounced; advances hours by one.
- `hr_tens` out 2: hours tens digit, 0–2.
- `hr_ones` out 4: hours ones digit, BCD.
- `min_tens` out 3: minutes tens digit, 0–5.
- `min_ones` out 4: minutes ones digit, BCD.
- `sec_tens` out 3: seconds tens digit, 0–5.
- `sec_ones` out 4: seconds ones digit, BCD.
- `sec_tick` out 1: one-cycle pulse when seconds advance.
- `min_tick` out 1: one-cycle pulse when seconds wrap 59→00.
- `day_tick` out 1: one-cycle pulse when the clock wraps 23:59:59→00:00:00.

## Operation
- **Reset:** all digits read 00:00:00. All tick outputs and synchroniser/history flops are 0.
- **Edge detection:** `hit` passes through `SYNC_STAGES` flops, then one history flop. A rise is registered when the last sync stage is 1 and the history flop is 0.
  - Falling edges are ignored.
  - `hit` stuck at one level produces no ticks.
- **Advance on a rise with `run`=1:**
  - `sec_ones` increments. At 9 it wraps to 0 and `sec_tens` increments.
  - At 59 the seconds wrap to 00, minutes carry, and `min_tick` pulses.
  - Minutes carry into hours the same way.
  - Hours wrap from 23 to 00. A wrap from 23:59:59 pulses `day_tick`.
  - All carries resolve in the same cycle.
- **`run`=0:**
  - A rise is consumed: the synchroniser and history flops keep tracking `hit`.
  - No time change and no tick pulses.
  - Raising `run` again never produces a catch-up or a spurious tick.
- **`set_min`:** minutes +1 with wrap 59→00. Hours are never carried and `min_tick` does not pulse. Seconds are unaffected.
- **`set_hour`:** hours +1 with wrap 23→00. `day_tick` does not pulse.
- **Priority, highest first:** `clear`, then set, then tick.
  - **`clear`:** forces 00:00:00 and suppresses all ticks that cycle.
  - **Set and rise in the same cycle:** seconds still advance and `sec_tick` pulses. Any seconds→minutes carry is dropped, and `min_tick`/`day_tick` stay 0.
  - **Set field:** each set field advances exactly once.
  - **`set_min` and `set_hour` together:** both fields advance by one each. There is no carry between them.
- **Digit range:** digits never leave their legal ranges. Illegal BCD is unreachable.

## Timing
- **Latency with `SYNC_STAGES`=2:** `hit` rises before edge k. The digits update at edge k+2 and `sec_tick` is high for the cycle following edge k+2. Each extra stage adds one cycle.
- **Tick outputs:** `min_tick` and `day_tick` are registered in the same cycle as the `sec_tick` that caused them. Each tick is exactly one cycle wide.
- **Set:** `set_min`/`set_hour` high before edge k → field updated at edge k, so latency is 1.
- **`clear`:** high before edge k → outputs are 00:00:00 after edge k. Ticks are 0 during the following cycle.
- **Minimum `hit` period:** 2×(`SYNC_STAGES`+1) cycles. Shorter pulses may be lost; this is not an error.
- **Reset mid-operation:**
  - Asserting `reset` zeroes everything asynchronously.
  - After deassertion, a `hit` already high counts as a rise once it reaches the last stage. The history flop resets to 0, so at most one tick results.

## Test plan
- **Reset and first tick:** assert `reset` low, release, toggle `hit` every 4 cycles for 5 rises → digits 00:00:05. Exactly 5 `sec_tick` pulses, each 1 cycle, each 3 cycles after its `hit` rise.
- **Day wrap:** set the time to 23:59:58 via set pulses plus ticks, then give 2 rises → 23:59:59, then 00:00:00. `min_tick` and `day_tick` pulse together with the second `sec_tick`.
- **Run gating:** `run`=0 across 3 rises, then `run`=1 with `hit` held high → time unchanged and no tick pulses. The next rise advances by exactly one second.
- **Collision:** at 00:00:59 assert `set_min` in the same cycle the rise registers → 00:01:00. Minutes advance once, `sec_tick`=1, `min_tick`=0.
- **Clear versus tick:** `clear` coincident with a rise at 12:34:56 → 00:00:00 with no tick pulses. The next rise → 00:00:01.
- **Set wrap:** 60 `set_min` pulses from 05:00:xx → 05:00:xx. 24 `set_hour` pulses → hours unchanged. No `min_tick` or `day_tick` during either sequence.

Source files
------------

// File: rtl/time_keeper.sv
// Time-of-day counter: turns each rising edge of the seconds square wave into
// one second of advance on a 24-hour BCD hh:mm:ss clock, with set/clear controls.
module time_keeper #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       hit,
    input  logic       run,
    input  logic       clear,
    input  logic       set_min,
    input  logic       set_hour,
    output logic [1:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       day_tick
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [1:0]             hr_tens_q, hr_tens_d;
    logic [3:0]             hr_ones_q, hr_ones_d;
    logic [2:0]             min_tens_q, min_tens_d;
    logic [3:0]             min_ones_q, min_ones_d;
    logic [2:0]             sec_tens_q, sec_tens_d;
    logic [3:0]             sec_ones_q, sec_ones_d;
    logic                   sec_tick_q, sec_tick_d;
    logic                   min_tick_q, min_tick_d;
    logic                   day_tick_q, day_tick_d;

    logic rise_c, adv_c, set_c;
    logic sec_wrap_c, min_wrap_c, hr_wrap_c;
    logic min_inc_c, hr_inc_c, carry_c;

    // Rise detect at the end of the synchroniser; run only gates the use of it
    assign rise_c     = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign adv_c      = rise_c & run;
    assign set_c      = set_min | set_hour;
    assign sec_wrap_c = (sec_tens_q == 3'd5) && (sec_ones_q == 4'd9);
    assign min_wrap_c = (min_tens_q == 3'd5) && (min_ones_q == 4'd9);
    assign hr_wrap_c  = (hr_tens_q == 2'd2) && (hr_ones_q == 4'd3);
    // A set in the same cycle drops the seconds carry entirely
    assign carry_c    = adv_c & sec_wrap_c & ~set_c;
    assign min_inc_c  = set_min | carry_c;
    assign hr_inc_c   = set_hour | (carry_c & min_wrap_c);

    // Next-state for synchroniser, digits and tick pulses
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], hit};
        hist_d     = sync_q[SYNC_STAGES-1];
        hr_tens_d  = hr_tens_q;
        hr_ones_d  = hr_ones_q;
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        sec_tick_d = 1'b0;
        min_tick_d = 1'b0;
        day_tick_d = 1'b0;

        if (clear) begin
            hr_tens_d  = 2'd0;
            hr_ones_d  = 4'd0;
            min_tens_d = 3'd0;
            min_ones_d = 4'd0;
            sec_tens_d = 3'd0;
            sec_ones_d = 4'd0;
        end else begin
            if (adv_c) begin
                sec_tick_d = 1'b1;
                if (sec_ones_q == 4'd9) begin
                    sec_ones_d = 4'd0;
                    sec_tens_d = sec_wrap_c ? 3'd0 : sec_tens_q + 3'd1;
                end else begin
                    sec_ones_d = sec_ones_q + 4'd1;
                end
            end

            min_tick_d = carry_c;
            day_tick_d = carry_c & min_wrap_c & hr_wrap_c;

            if (min_inc_c) begin
                if (min_ones_q == 4'd9) begin
                    min_ones_d = 4'd0;
                    min_tens_d = min_wrap_c ? 3'd0 : min_tens_q + 3'd1;
                end else begin
                    min_ones_d = min_ones_q + 4'd1;
                end
            end

            if (hr_inc_c) begin
                if (hr_wrap_c) begin
                    hr_tens_d = 2'd0;
                    hr_ones_d = 4'd0;
                end else if (hr_ones_q == 4'd9) begin
                    hr_tens_d = hr_tens_q + 2'd1;
                    hr_ones_d = 4'd0;
                end else begin
                    hr_ones_d = hr_ones_q + 4'd1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            hist_q     <= 1'b0;
            hr_tens_q  <= 2'd0;
            hr_ones_q  <= 4'd0;
            min_tens_q <= 3'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 3'd0;
            sec_ones_q <= 4'd0;
            sec_tick_q <= 1'b0;
            min_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            hr_tens_q  <= hr_tens_d;
            hr_ones_q  <= hr_ones_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            sec_tick_q <= sec_tick_d;
            min_tick_q <= min_tick_d;
            day_tick_q <= day_tick_d;
        end
    end

    assign hr_tens  = hr_tens_q;
    assign hr_ones  = hr_ones_q;
    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign sec_tick = sec_tick_q;
    assign min_tick = min_tick_q;
    assign day_tick = day_tick_q;

endmodule
